// File: rtl/frontend_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : frontend_redirect_ctrl
// Brief    : Prioritized backend/predecode/P1 redirect issue with flush and
//            recovery-stall sequencing plus per-cause redirect counters.
// Revision : 1.0
// ============================================================================
module frontend_redirect_ctrl #(
   parameter int FTQ_SIZE       = 8,
   parameter int ADDR_WIDTH     = 32,
   parameter int RECOVER_CYCLES = 2,
   localparam int PTR_WIDTH     = $clog2(FTQ_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  backend_redirect_valid_i,
   input  logic [ADDR_WIDTH-1:0] backend_redirect_pc_i,
   input  logic [PTR_WIDTH-1:0]  backend_redirect_ftq_id_i,
   input  logic                  predecode_redirect_valid_i,
   input  logic [ADDR_WIDTH-1:0] predecode_redirect_pc_i,
   input  logic [PTR_WIDTH-1:0]  predecode_redirect_ftq_id_i,
   input  logic                  bpu_p1_redirect_valid_i,
   input  logic [ADDR_WIDTH-1:0] bpu_p1_redirect_pc_i,
   output logic                  bpu_redirect_valid_o,
   output logic [ADDR_WIDTH-1:0] bpu_redirect_pc_o,
   output logic                  ftq_flush_valid_o,
   output logic [PTR_WIDTH-1:0]  ftq_flush_id_o,
   output logic                  ifu_flush_o,
   output logic                  frontend_stall_o,
   output logic [1:0]            redirect_cause_o,
   output logic [31:0]           backend_redirect_cnt_o,
   output logic [31:0]           predecode_redirect_cnt_o
);

   localparam int c_CNT_W = (RECOVER_CYCLES > 0) ? $clog2(RECOVER_CYCLES + 1) : 1;
   localparam logic [c_CNT_W-1:0] c_RECOVER_LOAD = c_CNT_W'(RECOVER_CYCLES);
   localparam logic [1:0] c_CAUSE_NONE      = 2'd0;
   localparam logic [1:0] c_CAUSE_BACKEND   = 2'd1;
   localparam logic [1:0] c_CAUSE_PREDECODE = 2'd2;
   localparam logic [1:0] c_CAUSE_P1        = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FLUSH   = 2'd1,
      S_RECOVER = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_CNT_W-1:0]    r_cnt;
   logic [c_CNT_W-1:0]    w_cnt_nxt;
   logic                  r_bpu_valid;
   logic [ADDR_WIDTH-1:0] r_bpu_pc;
   logic                  r_ftq_valid;
   logic [PTR_WIDTH-1:0]  r_ftq_id;
   logic                  r_ifu_flush;
   logic                  r_stall;
   logic [1:0]            r_cause;
   logic [31:0]           r_bk_cnt;
   logic [31:0]           r_pd_cnt;

   logic                  w_bk_acc;
   logic                  w_pd_acc;
   logic                  w_p1_acc;
   logic                  w_flush_go;
   logic [ADDR_WIDTH-1:0] w_pc_nxt;
   logic [PTR_WIDTH-1:0]  w_id_nxt;
   logic [1:0]            w_cause_nxt;

   always_comb begin
      w_bk_acc    = backend_redirect_valid_i;
      w_pd_acc    = predecode_redirect_valid_i && !backend_redirect_valid_i
                    && (r_state == S_IDLE);
      w_p1_acc    = bpu_p1_redirect_valid_i && !backend_redirect_valid_i
                    && !predecode_redirect_valid_i && (r_state == S_IDLE);
      w_flush_go  = w_bk_acc || w_pd_acc;
      w_pc_nxt    = bpu_p1_redirect_pc_i;
      w_id_nxt    = predecode_redirect_ftq_id_i;
      w_cause_nxt = c_CAUSE_NONE;
      if (w_bk_acc) begin
         w_pc_nxt    = backend_redirect_pc_i;
         w_id_nxt    = backend_redirect_ftq_id_i;
         w_cause_nxt = c_CAUSE_BACKEND;
      end else if (w_pd_acc) begin
         w_pc_nxt    = predecode_redirect_pc_i;
         w_cause_nxt = c_CAUSE_PREDECODE;
      end else if (w_p1_acc) begin
         w_cause_nxt = c_CAUSE_P1;
      end
   end

   // The recover counter is (re)loaded in every FLUSH cycle, so a backend
   // redirect arriving mid-recovery restarts the full window.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: w_state_nxt = S_IDLE;
         S_FLUSH: begin
            w_cnt_nxt   = c_RECOVER_LOAD;
            w_state_nxt = (RECOVER_CYCLES > 0) ? S_RECOVER : S_IDLE;
         end
         S_RECOVER: begin
            w_cnt_nxt   = r_cnt - c_CNT_W'(1);
            w_state_nxt = (r_cnt <= c_CNT_W'(1)) ? S_IDLE : S_RECOVER;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_flush_go) begin
         w_state_nxt = S_FLUSH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bpu_valid <= 1'b0;
         r_bpu_pc    <= '0;
         r_ftq_valid <= 1'b0;
         r_ftq_id    <= '0;
         r_ifu_flush <= 1'b0;
         r_stall     <= 1'b0;
         r_cause     <= c_CAUSE_NONE;
         r_bk_cnt    <= '0;
         r_pd_cnt    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bpu_valid <= w_flush_go || w_p1_acc;
         r_ftq_valid <= w_flush_go;
         r_ifu_flush <= w_flush_go;
         r_stall     <= (w_state_nxt != S_IDLE);
         r_cause     <= w_cause_nxt;
         if (w_flush_go || w_p1_acc) begin
            r_bpu_pc <= w_pc_nxt;
         end
         if (w_flush_go) begin
            r_ftq_id <= w_id_nxt;
         end
         if (w_bk_acc) begin
            r_bk_cnt <= r_bk_cnt + 32'd1;
         end
         if (w_pd_acc) begin
            r_pd_cnt <= r_pd_cnt + 32'd1;
         end
      end
   end

   assign bpu_redirect_valid_o     = r_bpu_valid;
   assign bpu_redirect_pc_o        = r_bpu_pc;
   assign ftq_flush_valid_o        = r_ftq_valid;
   assign ftq_flush_id_o           = r_ftq_id;
   assign ifu_flush_o              = r_ifu_flush;
   assign frontend_stall_o         = r_stall;
   assign redirect_cause_o         = r_cause;
   assign backend_redirect_cnt_o   = r_bk_cnt;
   assign predecode_redirect_cnt_o = r_pd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frontend_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_frontend_redirect_ctrl
// Brief    : Directed + random stimulus against a timeline model, driving a
//            RECOVER_CYCLES=2 and a RECOVER_CYCLES=0 instance in parallel.
// Revision : 1.0
// ============================================================================
module tb_frontend_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        bk_v, pd_v, p1_v;
   logic [31:0] bk_pc, pd_pc, p1_pc;
   logic [2:0]  bk_id, pd_id;

   logic        o_bv  [2];
   logic [31:0] o_bpc [2];
   logic        o_fv  [2];
   logic [2:0]  o_fid [2];
   logic        o_ifu [2];
   logic        o_stl [2];
   logic [1:0]  o_cau [2];
   logic [31:0] o_bcnt[2];
   logic [31:0] o_pcnt[2];

   // Model state: a flush accepted at cycle t keeps the frontend busy until idle_at = t+2+rc.
   int          idle_at[2];
   logic [31:0] m_bcnt[2];
   logic [31:0] m_pcnt[2];
   logic        e_bv[2], e_fv[2], e_ifu[2], e_stl[2];
   logic [31:0] e_bpc[2];
   logic [2:0]  e_fid[2];
   logic [1:0]  e_cau[2];
   int          cyc;
   int          errors;
   int          checks;

   always #5 clk = ~clk;

   frontend_redirect_ctrl #(.FTQ_SIZE(8), .ADDR_WIDTH(32), .RECOVER_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .backend_redirect_valid_i(bk_v), .backend_redirect_pc_i(bk_pc),
      .backend_redirect_ftq_id_i(bk_id),
      .predecode_redirect_valid_i(pd_v), .predecode_redirect_pc_i(pd_pc),
      .predecode_redirect_ftq_id_i(pd_id),
      .bpu_p1_redirect_valid_i(p1_v), .bpu_p1_redirect_pc_i(p1_pc),
      .bpu_redirect_valid_o(o_bv[0]), .bpu_redirect_pc_o(o_bpc[0]),
      .ftq_flush_valid_o(o_fv[0]), .ftq_flush_id_o(o_fid[0]),
      .ifu_flush_o(o_ifu[0]), .frontend_stall_o(o_stl[0]),
      .redirect_cause_o(o_cau[0]),
      .backend_redirect_cnt_o(o_bcnt[0]), .predecode_redirect_cnt_o(o_pcnt[0])
   );

   frontend_redirect_ctrl #(.FTQ_SIZE(8), .ADDR_WIDTH(32), .RECOVER_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst),
      .backend_redirect_valid_i(bk_v), .backend_redirect_pc_i(bk_pc),
      .backend_redirect_ftq_id_i(bk_id),
      .predecode_redirect_valid_i(pd_v), .predecode_redirect_pc_i(pd_pc),
      .predecode_redirect_ftq_id_i(pd_id),
      .bpu_p1_redirect_valid_i(p1_v), .bpu_p1_redirect_pc_i(p1_pc),
      .bpu_redirect_valid_o(o_bv[1]), .bpu_redirect_pc_o(o_bpc[1]),
      .ftq_flush_valid_o(o_fv[1]), .ftq_flush_id_o(o_fid[1]),
      .ifu_flush_o(o_ifu[1]), .frontend_stall_o(o_stl[1]),
      .redirect_cause_o(o_cau[1]),
      .backend_redirect_cnt_o(o_bcnt[1]), .predecode_redirect_cnt_o(o_pcnt[1])
   );

   task automatic chk(input string tag, input int k, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s rc%0d cyc=%0d observed=%h expected=%h", tag,
                (k == 0) ? 2 : 0, cyc, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic bv, input logic [31:0] bpc,
                       input logic [2:0] bid, input logic pv, input logic [31:0] ppc,
                       input logic [2:0] pid, input logic qv, input logic [31:0] qpc);
      rst = r; bk_v = bv; bk_pc = bpc; bk_id = bid;
      pd_v = pv; pd_pc = ppc; pd_id = pid; p1_v = qv; p1_pc = qpc;
      for (int k = 0; k < 2; k++) begin
         int rc;
         bit idle;
         rc   = (k == 0) ? 2 : 0;
         idle = (cyc >= idle_at[k]);
         e_bv[k] = 0; e_fv[k] = 0; e_ifu[k] = 0; e_cau[k] = 2'd0;
         if (r) begin
            m_bcnt[k] = 0; m_pcnt[k] = 0; idle_at[k] = cyc + 1;
            e_bpc[k] = 0; e_fid[k] = 0;
         end else if (bv) begin
            e_bv[k] = 1; e_fv[k] = 1; e_ifu[k] = 1; e_cau[k] = 2'd1;
            e_bpc[k] = bpc; e_fid[k] = bid;
            m_bcnt[k]++; idle_at[k] = cyc + 2 + rc;
         end else if (pv && idle) begin
            e_bv[k] = 1; e_fv[k] = 1; e_ifu[k] = 1; e_cau[k] = 2'd2;
            e_bpc[k] = ppc; e_fid[k] = pid;
            m_pcnt[k]++; idle_at[k] = cyc + 2 + rc;
         end else if (qv && idle) begin
            e_bv[k] = 1; e_cau[k] = 2'd3; e_bpc[k] = qpc;
         end
         e_stl[k] = !r && (cyc + 1 < idle_at[k]);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         chk("bpu_valid", k, 32'(o_bv[k]), 32'(e_bv[k]));
         chk("ftq_flush", k, 32'(o_fv[k]), 32'(e_fv[k]));
         chk("ifu_flush", k, 32'(o_ifu[k]), 32'(e_ifu[k]));
         chk("stall", k, 32'(o_stl[k]), 32'(e_stl[k]));
         chk("bk_cnt", k, o_bcnt[k], m_bcnt[k]);
         chk("pd_cnt", k, o_pcnt[k], m_pcnt[k]);
         if (e_bv[k] || r) begin
            chk("pc", k, o_bpc[k], e_bpc[k]);
            chk("cause", k, 32'(o_cau[k]), 32'(e_cau[k]));
         end
         if (e_fv[k] || r) chk("ftq_id", k, 32'(o_fid[k]), 32'(e_fid[k]));
      end
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic backend(input logic [31:0] pc, input logic [2:0] id);
      step(0, 1, pc, id, 0, 0, 0, 0, 0);
   endtask

   initial begin
      errors = 0; checks = 0; cyc = 0;
      idle_at[0] = 0; idle_at[1] = 0;
      m_bcnt[0] = 0; m_bcnt[1] = 0; m_pcnt[0] = 0; m_pcnt[1] = 0;

      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle_n(1);
      // Basic backend flush and recovery window
      backend(32'h1c00_0100, 3'd3);
      idle_n(4);
      // Backend and predecode together; predecode in RECOVER; then predecode in IDLE
      step(0, 1, 32'h1c00_0200, 3'd2, 1, 32'h1c00_0040, 3'd5, 0, 0);
      idle_n(1);
      step(0, 0, 0, 0, 1, 32'h1c00_0040, 3'd5, 0, 0);
      idle_n(2);
      step(0, 0, 0, 0, 1, 32'h1c00_0040, 3'd5, 0, 0);
      idle_n(4);
      // P1 in IDLE, then P1 during FLUSH
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1c00_0080);
      idle_n(1);
      backend(32'h1c00_0300, 3'd1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1c00_0084);
      idle_n(4);
      // Backend restarting the sequence from RECOVER, and back-to-back
      backend(32'h1c00_0400, 3'd4);
      idle_n(1);
      backend(32'h1c00_0500, 3'd6);
      idle_n(5);
      backend(32'h1c00_0600, 3'd7);
      backend(32'h1c00_0700, 3'd0);
      idle_n(5);
      // Reset mid-recovery
      backend(32'h1c00_0800, 3'd2);
      idle_n(1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle_n(2);

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 63) == 0),
              ($urandom_range(0, 7) == 0), $urandom, 3'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0), $urandom, 3'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0), $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
